// File: rtl/peripheral_bus_arbiter.sv
// Two-requester arbiter for the 12-bit peripheral register bus.
// Runs one transaction at a time, round-robin on ties, and ends unclaimed reads with an error ack.
//
// state   | meaning
// IDLE    | no transaction; arbitrate between m0_req and m1_req
// ACCESS  | captured command driven on the bus; wait for claim or timeout
// RESPOND | one-cycle ack/error/dataRead to the granted requester
module peripheral_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [11:0] m0_address,
    input  logic [3:0]  m0_byteSelect,
    input  logic [31:0] m0_dataWrite,
    output logic        m0_ack,
    output logic        m0_error,
    output logic [31:0] m0_dataRead,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [11:0] m1_address,
    input  logic [3:0]  m1_byteSelect,
    input  logic [31:0] m1_dataWrite,
    output logic        m1_ack,
    output logic        m1_error,
    output logic [31:0] m1_dataRead,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    output logic [11:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead,
    input  logic        peripheralBus_requestOutput,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t        state;
    logic          lastGrant;
    logic          grantM1;
    logic          cmdWe;
    logic [11:0]   cmdAddress;
    logic [3:0]    cmdByteSelect;
    logic [31:0]   cmdDataWrite;
    logic [CW-1:0] timeoutCount;

    logic          grantValid;
    logic          grantSel;
    logic          selWe;
    logic [11:0]   selAddress;
    logic [3:0]    selByteSelect;
    logic [31:0]   selDataWrite;
    logic          finishNow;
    logic          finishError;
    logic [31:0]   finishData;
    logic          inAccess;

    // Tie goes to whoever was not granted last; lastGrant=1 after reset lets m0 win the first tie.
    always_comb begin
        grantValid    = m0_req | m1_req;
        grantSel      = m1_req & (~m0_req | ~lastGrant);
        selWe         = grantSel ? m1_we         : m0_we;
        selAddress    = grantSel ? m1_address    : m0_address;
        selByteSelect = grantSel ? m1_byteSelect : m0_byteSelect;
        selDataWrite  = grantSel ? m1_dataWrite  : m0_dataWrite;
    end

    always_comb begin
        finishNow   = 1'b0;
        finishError = 1'b0;
        finishData  = '0;
        if (state == ACCESS) begin
            if (cmdWe) begin
                finishNow = 1'b1;
            end else if (peripheralBus_requestOutput) begin
                finishNow  = 1'b1;
                finishData = peripheralBus_dataRead;
            end else if (timeoutCount == TIMEOUT_LAST) begin
                finishNow   = 1'b1;
                finishError = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lastGrant     <= 1'b1;
            grantM1       <= 1'b0;
            cmdWe         <= 1'b0;
            cmdAddress    <= '0;
            cmdByteSelect <= '0;
            cmdDataWrite  <= '0;
            timeoutCount  <= '0;
            m0_ack        <= 1'b0;
            m0_error      <= 1'b0;
            m0_dataRead   <= '0;
            m1_ack        <= 1'b0;
            m1_error      <= 1'b0;
            m1_dataRead   <= '0;
        end else begin
            m0_ack      <= 1'b0;
            m0_error    <= 1'b0;
            m0_dataRead <= '0;
            m1_ack      <= 1'b0;
            m1_error    <= 1'b0;
            m1_dataRead <= '0;
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        grantM1       <= grantSel;
                        lastGrant     <= grantSel;
                        cmdWe         <= selWe;
                        cmdAddress    <= selAddress;
                        cmdByteSelect <= selByteSelect;
                        cmdDataWrite  <= selDataWrite;
                        timeoutCount  <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finishNow) begin
                        state <= RESPOND;
                        if (grantM1) begin
                            m1_ack      <= 1'b1;
                            m1_error    <= finishError;
                            m1_dataRead <= finishData;
                        end else begin
                            m0_ack      <= 1'b1;
                            m0_error    <= finishError;
                            m0_dataRead <= finishData;
                        end
                    end else begin
                        timeoutCount <= timeoutCount + CW'(1);
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus is decoded straight from the state register so reset removes the strobes immediately.
    assign inAccess                 = (state == ACCESS);
    assign busy                     = (state != IDLE);
    assign peripheralBus_we         = inAccess & cmdWe;
    assign peripheralBus_oe         = inAccess & ~cmdWe;
    assign peripheralBus_address    = inAccess ? cmdAddress    : '0;
    assign peripheralBus_byteSelect = inAccess ? cmdByteSelect : '0;
    assign peripheralBus_dataWrite  = inAccess ? cmdDataWrite  : '0;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter: expected acks are queued when a request is
// driven and popped when an ack appears, checking port, cycle, error and data.
module tb_peripheral_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteSelect, m1_byteSelect;
    logic [31:0] m0_dataWrite, m1_dataWrite;
    logic        m0_ack, m0_error, m1_ack, m1_error;
    logic [31:0] m0_dataRead, m1_dataRead;
    logic        peripheralBus_we, peripheralBus_oe;
    logic [11:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead;
    logic        peripheralBus_requestOutput;
    logic        busy;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] data;
        int          ackCyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    peripheral_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address),
        .m0_byteSelect(m0_byteSelect), .m0_dataWrite(m0_dataWrite),
        .m0_ack(m0_ack), .m0_error(m0_error), .m0_dataRead(m0_dataRead),
        .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address),
        .m1_byteSelect(m1_byteSelect), .m1_dataWrite(m1_dataWrite),
        .m1_ack(m1_ack), .m1_error(m1_error), .m1_dataRead(m1_dataRead),
        .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
        .peripheralBus_address(peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite(peripheralBus_dataWrite),
        .peripheralBus_dataRead(peripheralBus_dataRead),
        .peripheralBus_requestOutput(peripheralBus_requestOutput),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setCmd(input bit port, input logic we, input logic [11:0] addr,
                          input logic [3:0] bs, input logic [31:0] data);
        if (port) begin
            m1_we = we; m1_address = addr; m1_byteSelect = bs; m1_dataWrite = data;
        end else begin
            m0_we = we; m0_address = addr; m0_byteSelect = bs; m0_dataWrite = data;
        end
    endtask

    task automatic pushExp(input bit port, input bit err, input logic [31:0] data, input int ackCyc);
        exp_t e;
        e.port = port; e.err = err; e.data = data; e.ackCyc = ackCyc;
        sb.push_back(e);
    endtask

    task automatic checkAck();
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("ack_port", {30'd0, m1_ack, m0_ack}, e.port ? 32'd2 : 32'd1);
        chk("ack_cycle", cyc, e.ackCyc);
        chk("ack_error", {31'd0, e.port ? m1_error : m0_error}, {31'd0, e.err});
        chk("ack_data", e.port ? m1_dataRead : m0_dataRead, e.data);
        chk("other_quiet", e.port ? {m0_dataRead[30:0], m0_error} : {m1_dataRead[30:0], m1_error}, 32'd0);
        chk("busy_at_ack", {31'd0, busy}, 32'd1);
    endtask

    task automatic busIdleCheck();
        chk("we_oe_excl", {31'd0, peripheralBus_we & peripheralBus_oe}, 32'd0);
        if (!peripheralBus_we && !peripheralBus_oe)
            chk("bus_idle", {16'd0, peripheralBus_address, peripheralBus_byteSelect}
                | peripheralBus_dataWrite, 32'd0);
    endtask

    // claimK = ACCESS cycle in which a register answers (0 = never)
    task automatic doXfer(input bit port, input logic we, input logic [11:0] addr,
                          input logic [3:0] bs, input logic [31:0] wdata, input int claimK,
                          input logic [31:0] claimData, input bit dropAfterGrant);
        int c;
        int oeCnt = 0;
        int weCnt = 0;
        bit done = 0;
        int lat;
        @(negedge clk);
        setCmd(port, we, addr, bs, wdata);
        if (port) m1_req = 1'b1; else m0_req = 1'b1;
        c = cyc;
        lat = we ? 2 : (claimK == 0 ? 1 + TO : 1 + claimK);
        pushExp(port, !we && claimK == 0, (!we && claimK != 0) ? claimData : 32'd0, c + lat);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            busIdleCheck();
            peripheralBus_requestOutput = 1'b0;
            peripheralBus_dataRead = 32'd0;
            if (peripheralBus_we || peripheralBus_oe) begin
                chk("bus_addr", {20'd0, peripheralBus_address}, {20'd0, addr});
                chk("bus_bs", {28'd0, peripheralBus_byteSelect}, {28'd0, bs});
            end
            if (peripheralBus_we) begin
                weCnt++;
                chk("bus_wdata", peripheralBus_dataWrite, wdata);
            end
            if (peripheralBus_oe) begin
                oeCnt++;
                peripheralBus_requestOutput = (oeCnt == claimK);
                peripheralBus_dataRead = (oeCnt == claimK) ? claimData : (32'h0BAD0000 | oeCnt);
            end
            if (dropAfterGrant && busy) begin
                if (port) m1_req = 1'b0; else m0_req = 1'b0;
                setCmd(port, ~we, ~addr, ~bs, ~wdata);
            end
            if (m0_ack || m1_ack) begin
                checkAck();
                done = 1;
                if (port) m1_req = 1'b0; else m0_req = 1'b0;
            end
        end
        if (!done) begin
            chk("ack_timeout", {30'd0, m1_ack, m0_ack}, port ? 32'd2 : 32'd1);
            sb.delete();
        end
        chk("we_cycles", weCnt, we ? 32'd1 : 32'd0);
        chk("oe_cycles", oeCnt, we ? 32'd0 : (claimK == 0 ? TO : claimK));
        peripheralBus_requestOutput = 1'b0;
        peripheralBus_dataRead = 32'd0;
    endtask

    // Both requesters issue nEach writes back to back; grants must alternate starting at firstPort.
    task automatic doPair(input int nEach, input bit firstPort);
        int c;
        int acks = 0;
        int rem0 = nEach - 1;
        int rem1 = nEach - 1;
        @(negedge clk);
        setCmd(0, 1'b1, 12'h100, 4'hF, 32'hA0A0_0000);
        setCmd(1, 1'b1, 12'h200, 4'h3, 32'hB0B0_0000);
        m0_req = 1'b1;
        m1_req = 1'b1;
        c = cyc;
        for (int k = 0; k < 2 * nEach; k++)
            pushExp(firstPort ^ k[0], 1'b0, 32'd0, c + 2 + 3 * k);
        for (int i = 0; i < 40 && acks < 2 * nEach; i++) begin
            @(negedge clk);
            busIdleCheck();
            if (peripheralBus_we || peripheralBus_oe) chk("pair_busy", {31'd0, busy}, 32'd1);
            if (m0_ack || m1_ack) begin
                checkAck();
                acks++;
                if (m0_ack) begin
                    if (rem0 > 0) begin rem0--; m0_address = m0_address + 12'h1; end
                    else m0_req = 1'b0;
                end
                if (m1_ack) begin
                    if (rem1 > 0) begin rem1--; m1_address = m1_address + 12'h1; end
                    else m1_req = 1'b0;
                end
            end
        end
        chk("pair_acks", acks, 2 * nEach);
        m0_req = 1'b0;
        m1_req = 1'b0;
        sb.delete();
    endtask

    initial begin
        int oeSeen;
        rst = 1'b1;
        m0_req = 0; m1_req = 0;
        setCmd(0, 0, 0, 0, 0);
        setCmd(1, 0, 0, 0, 0);
        peripheralBus_dataRead = 0;
        peripheralBus_requestOutput = 0;
        repeat (2) @(negedge clk);
        chk("rst_acks", {m1_error, m1_ack, m0_error, m0_ack} | m0_dataRead | m1_dataRead, 32'd0);
        chk("rst_bus", {15'd0, peripheralBus_we, peripheralBus_oe, busy, peripheralBus_address,
            peripheralBus_byteSelect} | peripheralBus_dataWrite, 32'd0);
        rst = 1'b0;

        doPair(2, 1'b0);
        doXfer(0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        doXfer(1, 1'b0, 12'h010, 4'hF, 32'h0, 1, 32'hDEADBEEF, 0);
        doXfer(1, 1'b0, 12'hFFF, 4'hF, 32'h0, 0, 32'h0, 0);
        doXfer(0, 1'b0, 12'h044, 4'h6, 32'h0, 3, 32'h1234_5678, 1);
        doPair(1, 1'b1);
        doXfer(0, 1'b1, 12'h0AB, 4'h0, 32'h5555_AAAA, 0, 0, 0);

        // Reset in the middle of a read's ACCESS phase
        @(negedge clk);
        setCmd(1, 1'b0, 12'h020, 4'hF, 32'h0);
        m1_req = 1'b1;
        oeSeen = 0;
        for (int i = 0; i < 10 && oeSeen < 2; i++) begin
            @(negedge clk);
            if (peripheralBus_oe) oeSeen++;
        end
        chk("pre_rst_oe", oeSeen, 32'd2);
        rst = 1'b1;
        #1;
        chk("rst_async_bus", {29'd0, peripheralBus_oe, peripheralBus_we, busy}, 32'd0);
        chk("rst_async_addr", {20'd0, peripheralBus_address}, 32'd0);
        @(negedge clk);
        chk("rst_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        m1_req = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_quiet", {29'd0, m1_ack, m0_ack, busy}, 32'd0);
        end
        doXfer(1, 1'b1, 12'h030, 4'hC, 32'hCAFE_F00D, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        doPair(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
